mem_stage: RTL and testbench

Memory stage of the 5-stage MIPS pipeline, sitting directly downstream of the EX stage (ALU, forwarding muxes). It holds the EX/MEM pipeline register, runs the load/store handshake with an external data memory that may take several cycles, and produces the MEM/WB pipeline register consumed by write-back. It stalls upstream while an access is outstanding. It also exports EX/MEM and MEM/WB destination info to the Forwarding_Unit.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/mem_timeout_counter.sv | 39 +++
 rtl/mem_stage.sv | 136 +++++++++++++
 tb/tb_mem_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and widths for the MIPS pipeline stages.
package cpu_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // Memory-stage handshake states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  // Control bundle carried from ID_EX into the memory stage
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  // Word accesses only: the two low address bits must be zero
  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles an outstanding data-memory request has waited for ack.
module mem_timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds cycles already waited, so the current cycle is the TIMEOUT-th one
  assign expired_c = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, data-memory handshake, MEM/WB register.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ALU_Res_i,
  input  logic [31:0] RTdata_i,
  input  logic [4:0]  RdAddr_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic        EX_MEM_RegWrite_o,
  output logic [4:0]  EX_MEM_RdAddr_o,
  output logic [31:0] EX_MEM_ALU_Res_o,
  output logic        MEM_WB_RegWrite_o,
  output logic [4:0]  MEM_WB_RdAddr_o,
  output logic [31:0] MEM_WB_Data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  mem_state_e state_q, state_d;

  ctrl_t                  ctrl_q, ctrl_d;
  logic [WORD_W-1:0]      alu_q, alu_d;
  logic [WORD_W-1:0]      rt_q, rt_d;
  logic [REG_ADDR_W-1:0]  rd_q, rd_d;

  logic                   wb_rw_q, wb_rw_d;
  logic [REG_ADDR_W-1:0]  wb_rd_q, wb_rd_d;
  logic [WORD_W-1:0]      wb_data_q, wb_data_d;

  logic memop;
  logic access;
  logic abort;
  logic tmo_expired;
  logic cnt_en;
  logic cnt_clr;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (cnt_en),
    .clr_i     (cnt_clr),
    .expired_c (tmo_expired)
  );

  // Handshake FSM: next state, request, stall and error pulses
  always_comb begin
    state_d      = state_q;
    memop        = ctrl_q.mem_read | ctrl_q.mem_write;
    access       = memop & is_word_aligned(alu_q[1:0]);
    abort        = (state_q == ST_BUSY) & tmo_expired & ~dmem_ack_i;
    dmem_req_o   = access;
    dmem_we_o    = ctrl_q.mem_write;
    dmem_addr_o  = alu_q;
    dmem_wdata_o = rt_q;
    stall_o      = access & ~dmem_ack_i & ~abort;
    misalign_o   = memop & ~access;
    bus_err_o    = abort;
    cnt_en       = stall_o;
    cnt_clr      = ~stall_o;
    case (state_q)
      ST_IDLE: if (stall_o)  state_d = ST_BUSY;
      ST_BUSY: if (!stall_o) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pipeline register next values: EX/MEM holds on stall, MEM/WB bubbles unless the op retires
  always_comb begin
    ctrl_d    = ctrl_q;
    alu_d     = alu_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    wb_rw_d   = 1'b0;
    wb_rd_d   = '0;
    wb_data_d = '0;
    if (!stall_o) begin
      ctrl_d = '{reg_write: RegWrite_i, mem_to_reg: MemToReg_i,
                 mem_read: MemRead_i, mem_write: MemWrite_i};
      alu_d  = ALU_Res_i;
      rt_d   = RTdata_i;
      rd_d   = RdAddr_i;
      if (!misalign_o && !abort) begin
        wb_rw_d   = ctrl_q.reg_write;
        wb_rd_d   = rd_q;
        wb_data_d = ctrl_q.mem_to_reg ? dmem_rdata_i : alu_q;
      end
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      alu_q     <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      wb_rw_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      alu_q     <= alu_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      wb_rw_q   <= wb_rw_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign EX_MEM_RegWrite_o = ctrl_q.reg_write;
  assign EX_MEM_RdAddr_o   = rd_q;
  assign EX_MEM_ALU_Res_o  = alu_q;
  assign MEM_WB_RegWrite_o = wb_rw_q;
  assign MEM_WB_RdAddr_o   = wb_rd_q;
  assign MEM_WB_Data_o     = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus hand-written corner sequences.
module tb_mem_stage;

  localparam int unsigned TIMEOUT = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] ALU_Res_i, RTdata_i, dmem_rdata_i;
  logic [4:0]  RdAddr_i;
  logic        RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, dmem_ack_i;
  logic        dmem_req_o, dmem_we_o, stall_o, misalign_o, bus_err_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, EX_MEM_ALU_Res_o, MEM_WB_Data_o;
  logic        EX_MEM_RegWrite_o, MEM_WB_RegWrite_o;
  logic [4:0]  EX_MEM_RdAddr_o, MEM_WB_RdAddr_o;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .ALU_Res_i         (ALU_Res_i),
    .RTdata_i          (RTdata_i),
    .RdAddr_i          (RdAddr_i),
    .RegWrite_i        (RegWrite_i),
    .MemToReg_i        (MemToReg_i),
    .MemRead_i         (MemRead_i),
    .MemWrite_i        (MemWrite_i),
    .dmem_req_o        (dmem_req_o),
    .dmem_we_o         (dmem_we_o),
    .dmem_addr_o       (dmem_addr_o),
    .dmem_wdata_o      (dmem_wdata_o),
    .dmem_ack_i        (dmem_ack_i),
    .dmem_rdata_i      (dmem_rdata_i),
    .stall_o           (stall_o),
    .EX_MEM_RegWrite_o (EX_MEM_RegWrite_o),
    .EX_MEM_RdAddr_o   (EX_MEM_RdAddr_o),
    .EX_MEM_ALU_Res_o  (EX_MEM_ALU_Res_o),
    .MEM_WB_RegWrite_o (MEM_WB_RegWrite_o),
    .MEM_WB_RdAddr_o   (MEM_WB_RdAddr_o),
    .MEM_WB_Data_o     (MEM_WB_Data_o),
    .misalign_o        (misalign_o),
    .bus_err_o         (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t sb_q[$];

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic        rw, m2r, mr, mw;
    int          ack_cyc;   // cycle of ack within the MEM stay; 0 = never
    logic [31:0] rdata;
    logic        exp_rw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    int          exp_req, exp_stall, exp_mis, exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_check(input string nm);
    wb_t e;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: got empty scoreboard expected an entry", nm);
      return;
    end
    e = sb_q.pop_front();
    chk({nm, "_wb_rw"},   32'(MEM_WB_RegWrite_o), 32'(e.rw));
    chk({nm, "_wb_rd"},   32'(MEM_WB_RdAddr_o),   32'(e.rd));
    chk({nm, "_wb_data"}, MEM_WB_Data_o,          e.data);
  endtask

  task automatic drive_nop();
    RegWrite_i = 1'b0; MemToReg_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    ALU_Res_i  = $urandom();
    RTdata_i   = $urandom();
    RdAddr_i   = 5'($urandom());
  endtask

  task automatic drive_op(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd,
                          input logic rw, input logic m2r, input logic mr, input logic mw);
    ALU_Res_i = alu; RTdata_i = rt; RdAddr_i = rd;
    RegWrite_i = rw; MemToReg_i = m2r; MemRead_i = mr; MemWrite_i = mw;
  endtask

  // Entered and left at posedge+1; the vector occupies the MEM stage alone
  task automatic run_vec(input vec_t v, input int idx);
    int req_cnt = 0, stall_cnt = 0, mis_cnt = 0, err_cnt = 0;
    bit done = 0;
    bit stalled;
    string p = $sformatf("v%0d", idx);
    drive_op(v.alu, v.rt, v.rd, v.rw, v.m2r, v.mr, v.mw);
    sb_q.push_back('{v.exp_rw, v.exp_rd, v.exp_data});
    @(posedge clk_i); #1;
    drive_nop();
    chk({p, "_exmem_rw"},  32'(EX_MEM_RegWrite_o), 32'(v.rw));
    chk({p, "_exmem_rd"},  32'(EX_MEM_RdAddr_o),   32'(v.rd));
    chk({p, "_exmem_alu"}, EX_MEM_ALU_Res_o,       v.alu);
    for (int c = 1; c <= 40 && !done; c++) begin
      dmem_ack_i   = (v.ack_cyc == c);
      dmem_rdata_i = (v.ack_cyc == c) ? v.rdata : 32'hBAD0_0000 + 32'(c);
      @(negedge clk_i);
      if (dmem_req_o) begin
        req_cnt++;
        if (c == 1 || dmem_ack_i) begin
          chk({p, "_addr"},  dmem_addr_o,       v.alu);
          chk({p, "_we"},    32'(dmem_we_o),    32'(v.mw));
          chk({p, "_wdata"}, dmem_wdata_o,      v.rt);
        end
      end
      if (stall_o)    stall_cnt++;
      if (misalign_o) mis_cnt++;
      if (bus_err_o)  err_cnt++;
      stalled = stall_o;
      @(posedge clk_i); #1;
      if (stalled) begin
        chk({p, "_stall_bubble"}, 32'(MEM_WB_RegWrite_o), 32'd0);
        chk({p, "_frozen_alu"},   EX_MEM_ALU_Res_o,       v.alu);
      end else begin
        done = 1;
      end
    end
    dmem_ack_i = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_complete: got no completion expected one within 40 cycles", p);
    end
    sb_check(p);
    chk({p, "_req_cycles"},   32'(req_cnt),   32'(v.exp_req));
    chk({p, "_stall_cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
    chk({p, "_misalign"},     32'(mis_cnt),   32'(v.exp_mis));
    chk({p, "_bus_err"},      32'(err_cnt),   32'(v.exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    //            alu            rt            rd    rw m2r mr mw ack rdata          erw erd  edata          req stl mis err
    vecs[0] = '{32'h0000_0010, 32'h0,        5'd8,  1, 0, 0, 0, 0,  32'h0,         1, 5'd8,  32'h0000_0010, 0,  0,  0, 0};
    vecs[1] = '{32'h0000_0040, 32'h0,        5'd9,  1, 1, 1, 0, 1,  32'hDEAD_BEEF, 1, 5'd9,  32'hDEAD_BEEF, 1,  0,  0, 0};
    vecs[2] = '{32'h0000_0044, 32'h1234,     5'd0,  0, 0, 0, 1, 3,  32'h0,         0, 5'd0,  32'h0000_0044, 3,  2,  0, 0};
    vecs[3] = '{32'h0000_0042, 32'h0,        5'd9,  1, 1, 1, 0, 1,  32'h5555,      0, 5'd0,  32'h0,         0,  0,  1, 0};
    vecs[4] = '{32'h0000_0080, 32'h0,        5'd10, 1, 1, 1, 0, 0,  32'h0,         0, 5'd0,  32'h0,         16, 15, 0, 1};
    vecs[5] = '{32'h0000_0084, 32'h0,        5'd11, 1, 1, 1, 0, 2,  32'hCAFE_F00D, 1, 5'd11, 32'hCAFE_F00D, 2,  1,  0, 0};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0,        5'd0,  1, 0, 0, 0, 1,  32'h77,        1, 5'd0,  32'hFFFF_FFFF, 0,  0,  0, 0};
    vecs[7] = '{32'h0000_0045, 32'hAA,       5'd0,  0, 0, 0, 1, 1,  32'h0,         0, 5'd0,  32'h0,         0,  0,  1, 0};
    vecs[8] = '{32'h0000_008C, 32'h0,        5'd12, 1, 1, 1, 0, 16, 32'h0BAD_F00D, 1, 5'd12, 32'h0BAD_F00D, 16, 15, 0, 0};
    vecs[9] = '{32'h0000_0090, 32'h0,        5'd13, 1, 1, 1, 0, 15, 32'h1357_9BDF, 1, 5'd13, 32'h1357_9BDF, 15, 14, 0, 0};

    // Reset state, with a load presented at the inputs
    rst_i = 1'b0;
    dmem_ack_i = 1'b0;
    dmem_rdata_i = 32'h0;
    drive_op(32'h0000_0100, 32'h55, 5'd3, 1, 1, 1, 0);
    @(posedge clk_i); #1;
    chk("rst_req",       32'(dmem_req_o),        32'd0);
    chk("rst_stall",     32'(stall_o),           32'd0);
    chk("rst_exmem_alu", EX_MEM_ALU_Res_o,       32'd0);
    chk("rst_exmem_rw",  32'(EX_MEM_RegWrite_o), 32'd0);
    chk("rst_wb_rw",     32'(MEM_WB_RegWrite_o), 32'd0);
    chk("rst_wb_data",   MEM_WB_Data_o,          32'd0);
    chk("rst_misalign",  32'(misalign_o),        32'd0);
    chk("rst_bus_err",   32'(bus_err_o),         32'd0);
    drive_nop();
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Back-to-back zero-wait accesses: LW, LW, SW in consecutive cycles
    drive_op(32'h0000_0200, 32'h0, 5'd14, 1, 1, 1, 0);
    sb_q.push_back('{1'b1, 5'd14, 32'hA0A0_0001});
    @(posedge clk_i); #1;
    drive_op(32'h0000_0204, 32'h0, 5'd15, 1, 1, 1, 0);
    sb_q.push_back('{1'b1, 5'd15, 32'hB0B0_0002});
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hA0A0_0001;
    @(negedge clk_i);
    chk("b2b_a_req",   32'(dmem_req_o), 32'd1);
    chk("b2b_a_addr",  dmem_addr_o,     32'h0000_0200);
    chk("b2b_a_stall", 32'(stall_o),    32'd0);
    @(posedge clk_i); #1;
    sb_check("b2b_a");
    drive_op(32'h0000_0208, 32'h99, 5'd0, 0, 0, 0, 1);
    sb_q.push_back('{1'b0, 5'd0, 32'h0000_0208});
    dmem_rdata_i = 32'hB0B0_0002;
    @(negedge clk_i);
    chk("b2b_b_req",  32'(dmem_req_o), 32'd1);
    chk("b2b_b_addr", dmem_addr_o,     32'h0000_0204);
    @(posedge clk_i); #1;
    sb_check("b2b_b");
    drive_nop();
    dmem_rdata_i = 32'h1111_2222;
    @(negedge clk_i);
    chk("b2b_c_addr",  dmem_addr_o,     32'h0000_0208);
    chk("b2b_c_we",    32'(dmem_we_o),  32'd1);
    chk("b2b_c_wdata", dmem_wdata_o,    32'h99);
    @(posedge clk_i); #1;
    sb_check("b2b_c");
    dmem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("b2b_idle_req", 32'(dmem_req_o), 32'd0);
    @(posedge clk_i); #1;

    // Stalled load followed immediately by another load
    drive_op(32'h0000_0300, 32'h0, 5'd16, 1, 1, 1, 0);
    sb_q.push_back('{1'b1, 5'd16, 32'hD0D0_0003});
    @(posedge clk_i); #1;
    drive_op(32'h0000_0304, 32'h0, 5'd17, 1, 1, 1, 0);
    sb_q.push_back('{1'b1, 5'd17, 32'hE0E0_0004});
    @(negedge clk_i);
    chk("stl_d_stall", 32'(stall_o),  32'd1);
    chk("stl_d_addr",  dmem_addr_o,   32'h0000_0300);
    @(posedge clk_i); #1;
    chk("stl_d_bubble", 32'(MEM_WB_RegWrite_o), 32'd0);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hD0D0_0003;
    @(negedge clk_i);
    chk("stl_d_ack_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    sb_check("stl_d");
    drive_nop();
    dmem_rdata_i = 32'hE0E0_0004;
    @(negedge clk_i);
    chk("stl_e_req",  32'(dmem_req_o), 32'd1);
    chk("stl_e_addr", dmem_addr_o,     32'h0000_0304);
    @(posedge clk_i); #1;
    sb_check("stl_e");
    dmem_ack_i = 1'b0;
    @(posedge clk_i); #1;

    // Reset asserted while a load waits in BUSY
    drive_op(32'h0000_0400, 32'h0, 5'd5, 1, 1, 1, 0);
    @(posedge clk_i); #1;
    drive_nop();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rb_req_before", 32'(dmem_req_o), 32'd1);
    #1;
    rst_i = 1'b0;
    #1;
    chk("rb_req",       32'(dmem_req_o),        32'd0);
    chk("rb_stall",     32'(stall_o),           32'd0);
    chk("rb_exmem_alu", EX_MEM_ALU_Res_o,       32'd0);
    chk("rb_exmem_rd",  32'(EX_MEM_RdAddr_o),   32'd0);
    chk("rb_wb_rw",     32'(MEM_WB_RegWrite_o), 32'd0);
    chk("rb_wb_rd",     32'(MEM_WB_RdAddr_o),   32'd0);
    chk("rb_bus_err",   32'(bus_err_o),         32'd0);
    @(negedge clk_i); #2;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    run_vec(vecs[9], 19);
    run_vec(vecs[1], 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
